bch_encoder_serial: RTL and testbench



---
 rtl/bch_encoder_serial_pkg.sv | 20 ++
 rtl/bch_encoder_serial_if.sv | 27 ++
 rtl/bch_encoder_serial_lfsr_div.sv | 32 +++
 rtl/bch_encoder_serial.sv | 127 ++++++++++++
 tb/tb_bch_encoder_serial.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/bch_encoder_serial_pkg.sv
// Shared (15,7) BCH definitions: code sizes, generator polynomial, word types and
// the serial encoder state encoding. Also imported by the syndrome decoder.
package bch15_7_pkg;

  localparam int unsigned N  = 15;
  localparam int unsigned K  = 7;
  localparam int unsigned NK = N - K;
  localparam logic [8:0]  GEN_POLY = 9'b111010001;

  typedef logic [K-1:0]  message_t;
  typedef logic [N-1:0]  codeword_t;
  typedef logic [NK-1:0] syndrome_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/bch_encoder_serial_if.sv
// Message-in / codeword-out handshake bundle of the serial BCH encoder.
// Optional BCH_ENC_ERR_INJECT_EN adds the error mask input and injected flag.
interface bch_encoder_serial_if;
  import bch15_7_pkg::*;

  message_t  i_Message;
  logic      i_MsgValid;
  logic      o_MsgReady;
  codeword_t o_CodeWord;
  logic      o_CwValid;
  logic      i_CwReady;
  logic      o_Busy;
`ifdef BCH_ENC_ERR_INJECT_EN
  codeword_t i_ErrMask;
  logic      o_Injected;

  modport master (output i_Message, i_MsgValid, i_CwReady, i_ErrMask,
                  input  o_MsgReady, o_CodeWord, o_CwValid, o_Busy, o_Injected);
  modport slave  (input  i_Message, i_MsgValid, i_CwReady, i_ErrMask,
                  output o_MsgReady, o_CodeWord, o_CwValid, o_Busy, o_Injected);
`else
  modport master (output i_Message, i_MsgValid, i_CwReady,
                  input  o_MsgReady, o_CodeWord, o_CwValid, o_Busy);
  modport slave  (input  i_Message, i_MsgValid, i_CwReady,
                  output o_MsgReady, o_CodeWord, o_CwValid, o_Busy);
`endif
endinterface

// File: rtl/bch_encoder_serial_lfsr_div.sv
// One-bit-per-clock polynomial division step (MSB first) with clear and enable.
// rem_next is the value the remainder register takes on the coming edge.
module bch_lfsr_div #(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  TAPS = 8'hD1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] rem_next
);
  logic [W-1:0] rem_q, rem_d;
  logic         fb;

  always_comb begin
    fb    = din ^ rem_q[W-1];
    rem_d = rem_q;
    if (clr)
      rem_d = '0;
    else if (en)
      rem_d = {rem_q[W-2:0], 1'b0} ^ (fb ? TAPS : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

  assign rem_next = rem_d;
endmodule

// File: rtl/bch_encoder_serial.sv
// Systematic serial (15,7) BCH encoder: 7 LFSR cycles per message, codeword = {msg, parity}.
// Optional BCH_ENC_ERR_INJECT_EN: XOR a per-message error mask into the output codeword.
module bch_encoder_serial
  import bch15_7_pkg::*;
#(
  parameter logic [8:0]  GeneratorPolinomial = GEN_POLY,
  parameter int unsigned N = 15,
  parameter int unsigned K = 7
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  bch_encoder_serial_if.slave  bus
);
  localparam int unsigned NK_W = N - K;

  enc_state_e state_q, state_d;
  message_t   msg_q, msg_d;
  message_t   sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       msg_ready_q, msg_ready_d;
  logic       cw_valid_q, cw_valid_d;
  logic       busy_q, busy_d;
  codeword_t  cw_q, cw_d;
  codeword_t  mask_q, mask_d;
`ifdef BCH_ENC_ERR_INJECT_EN
  logic       inj_q, inj_d;
`endif

  logic       lfsr_clr, lfsr_en;
  syndrome_t  lfsr_next;

  bch_lfsr_div #(
    .W    (NK_W),
    .TAPS (GeneratorPolinomial[NK_W-1:0])
  ) u_lfsr (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .clr      (lfsr_clr),
    .en       (lfsr_en),
    .din      (sr_q[K-1]),
    .rem_next (lfsr_next)
  );

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    cw_d     = cw_q;
    mask_d   = mask_q;
    lfsr_clr = 1'b0;
    lfsr_en  = 1'b0;
`ifdef BCH_ENC_ERR_INJECT_EN
    inj_d    = inj_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_MsgValid) begin
          msg_d    = bus.i_Message;
          sr_d     = bus.i_Message;
          cnt_d    = '0;
          lfsr_clr = 1'b1;
          state_d  = ST_CALC;
`ifdef BCH_ENC_ERR_INJECT_EN
          mask_d   = bus.i_ErrMask;
          inj_d    = |bus.i_ErrMask;
`endif
        end
      end
      ST_CALC: begin
        lfsr_en = 1'b1;
        sr_d    = {sr_q[K-2:0], 1'b0};
        cnt_d   = cnt_q + 3'd1;
        // Capture the codeword from the final division step so it is valid on entry to OUT.
        if (cnt_q == 3'(K-1)) begin
          cw_d    = {msg_q, lfsr_next} ^ mask_q;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (bus.i_CwReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    msg_ready_d = (state_d == ST_IDLE);
    cw_valid_d  = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      msg_q       <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      msg_ready_q <= 1'b1;
      cw_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cw_q        <= '0;
      mask_q      <= '0;
`ifdef BCH_ENC_ERR_INJECT_EN
      inj_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      msg_ready_q <= msg_ready_d;
      cw_valid_q  <= cw_valid_d;
      busy_q      <= busy_d;
      cw_q        <= cw_d;
      mask_q      <= mask_d;
`ifdef BCH_ENC_ERR_INJECT_EN
      inj_q       <= inj_d;
`endif
    end
  end

  assign bus.o_MsgReady = msg_ready_q;
  assign bus.o_CwValid  = cw_valid_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_CodeWord = cw_q;
`ifdef BCH_ENC_ERR_INJECT_EN
  assign bus.o_Injected = inj_q;
`endif
endmodule

// File: tb/tb_bch_encoder_serial.sv
// Directed bench for bch_encoder_serial: vector table, backpressure, reset mid-calc,
// exhaustive messages with random ready, and the optional error-injection path.
module tb_bch_encoder_serial;
  import bch15_7_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  bch_encoder_serial_if bus();

  bch_encoder_serial #(
    .GeneratorPolinomial (9'b111010001),
    .N (15),
    .K (7)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  msg;
    logic [14:0] cw;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Long division of a 15-bit polynomial by g(x); returns the 8-bit remainder.
  function automatic logic [7:0] poly_rem(input logic [14:0] w);
    logic [14:0] r;
    logic [14:0] g;
    r = w;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) begin
        g = 15'(GEN_POLY) << (i - 8);
        r = r ^ g;
      end
    end
    return r[7:0];
  endfunction

  function automatic logic [14:0] model_enc(input logic [6:0] m);
    return {m, poly_rem({m, 8'h00})};
  endfunction

  // Called at posedge+#1 with the DUT idle. Returns codeword, edges from accept to
  // valid, and the cycle number of the accept edge.
  task automatic run_one(input logic [6:0] m, input int hold,
                         output logic [14:0] cw, output int lat, output int acc_cyc);
    bus.i_Message  = m;
    bus.i_MsgValid = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.i_MsgValid = 1'b0;
    lat = 0;
    while (!bus.o_CwValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (hold) begin @(posedge clk); #1; end
    cw = bus.o_CodeWord;
    bus.i_CwReady = 1'b1;
    @(posedge clk); #1;
    bus.i_CwReady = 1'b0;
  endtask

  initial begin
    logic [14:0] cw, held;
    int lat, acc, prev_acc;
    bit stable_ok;

    vecs[0] = '{7'b1000000, 15'h40E8};
    vecs[1] = '{7'b0000001, 15'h01D1};
    vecs[2] = '{7'h7F,      15'h7FFF};
    vecs[3] = '{7'h00,      15'h0000};
    vecs[4] = '{7'h2A,      15'h2A1A};
    vecs[5] = '{7'h55,      15'h55E5};

    bus.i_Message  = '0;
    bus.i_MsgValid = 1'b0;
    bus.i_CwReady  = 1'b0;
`ifdef BCH_ENC_ERR_INJECT_EN
    bus.i_ErrMask  = '0;
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_msgready", 32'(bus.o_MsgReady), 32'd1);
    check("rst_cwvalid",  32'(bus.o_CwValid),  32'd0);
    check("rst_busy",     32'(bus.o_Busy),     32'd0);
    check("rst_codeword", 32'(bus.o_CodeWord), 32'h0);
`ifdef BCH_ENC_ERR_INJECT_EN
    check("rst_injected", 32'(bus.o_Injected), 32'd0);
`endif

    // Directed table; valid is already high when edge T+8 samples it (7 edges after accept).
    for (int i = 0; i < 6; i++) begin
      run_one(vecs[i].msg, 0, cw, lat, acc);
      check($sformatf("vec%0d_cw", i), 32'(cw), 32'(vecs[i].cw));
      check($sformatf("vec%0d_lat", i), lat, 7);
      check($sformatf("vec%0d_idle", i), {30'd0, bus.o_MsgReady, bus.o_CwValid}, 32'h2);
    end

    // Backpressure: hold ready low 20 cycles, pulse a second valid mid-way.
    bus.i_Message  = 7'h2A;
    bus.i_MsgValid = 1'b1;
    @(posedge clk); #1;
    bus.i_MsgValid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("bp_valid", 32'(bus.o_CwValid), 32'd1);
    held = bus.o_CodeWord;
    check("bp_cw", 32'(held), 32'h2A1A);
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin bus.i_Message = 7'h7F; bus.i_MsgValid = 1'b1; end
      if (c == 6) bus.i_MsgValid = 1'b0;
      @(posedge clk); #1;
      if (bus.o_CodeWord !== held || bus.o_MsgReady !== 1'b0 ||
          bus.o_CwValid !== 1'b1 || bus.o_Busy !== 1'b1) stable_ok = 1'b0;
    end
    check("bp_stable", 32'(stable_ok), 32'd1);
    bus.i_CwReady = 1'b1;
    @(posedge clk); #1;
    bus.i_CwReady = 1'b0;
    check("bp_release", {29'd0, bus.o_MsgReady, bus.o_CwValid, bus.o_Busy}, 32'h4);
    repeat (3) begin @(posedge clk); #1; end
    check("bp_no_ghost", {29'd0, bus.o_MsgReady, bus.o_CwValid, bus.o_Busy}, 32'h4);
    check("bp_cw_kept", 32'(bus.o_CodeWord), 32'h2A1A);

    // Throughput: two back-to-back messages with immediate ready.
    run_one(7'h11, 0, cw, lat, prev_acc);
    run_one(7'h22, 0, cw, lat, acc);
    check("throughput", acc - prev_acc, 9);
    check("thr_cw", 32'(cw), 32'(model_enc(7'h22)));

    // All 128 messages back-to-back with random ready delay.
    for (int m = 0; m < 128; m++) begin
      run_one(7'(m), int'($urandom_range(0, 3)), cw, lat, acc);
      check($sformatf("all%0d_cw", m), 32'(cw), 32'(model_enc(7'(m))));
      check($sformatf("all%0d_rem", m), 32'(poly_rem(cw)), 32'h0);
    end

    // Reset during CALC cycle 3 discards the partial result.
    bus.i_Message  = 7'h7F;
    bus.i_MsgValid = 1'b1;
    @(posedge clk); #1;
    bus.i_MsgValid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_state", {29'd0, bus.o_MsgReady, bus.o_CwValid, bus.o_Busy}, 32'h4);
    check("midrst_cw", 32'(bus.o_CodeWord), 32'h0);
    run_one(7'b0000001, 1, cw, lat, acc);
    check("midrst_next_cw", 32'(cw), 32'h01D1);
    check("midrst_next_lat", lat, 7);

`ifdef BCH_ENC_ERR_INJECT_EN
    bus.i_ErrMask = 15'h0001;
    bus.i_Message = 7'h7F;
    bus.i_MsgValid = 1'b1;
    @(posedge clk); #1;
    bus.i_MsgValid = 1'b0;
    bus.i_ErrMask = '0;
    repeat (7) begin @(posedge clk); #1; end
    check("inj_cw", 32'(bus.o_CodeWord), 32'h7FFE);
    check("inj_flag", 32'(bus.o_Injected), 32'd1);
    check("inj_syn", 32'(poly_rem(bus.o_CodeWord)), 32'h01);
    bus.i_CwReady = 1'b1;
    @(posedge clk); #1;
    bus.i_CwReady = 1'b0;
    run_one(7'h7F, 0, cw, lat, acc);
    check("inj_clear_cw", 32'(cw), 32'h7FFF);
    check("inj_clear_flag", 32'(bus.o_Injected), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
